// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - fetch sequencer bus: ROM port, control inputs, prefetch head to ID
interface if_fetch_ctrl_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   rom_addr;
    logic [31:0]   rom_data;
    logic          fetch_en;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          id_ready;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;
    logic [31:0]   if_pc_plus4;
    logic [CW-1:0] q_count;

    modport master (
        output rom_addr, if_valid, if_instr, if_pc, if_pc_plus4, q_count,
        input  rom_data, fetch_en, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  rom_addr, if_valid, if_instr, if_pc, if_pc_plus4, q_count,
        output rom_data, fetch_en, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch sequencer: PC, ROM address, prefetch queue, redirect
module if_fetch_ctrl #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    if_fetch_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic          pop, push;

    always_ff @(posedge clk) begin
        if (!reset) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (!bus.fetch_en) state_nxt = HOLD;
            HOLD:    if (bus.fetch_en)  state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    assign pop  = bus.if_valid & bus.id_ready;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign push = (state == RUN) & bus.fetch_en & ~bus.redirect_valid & ((count < FULL) | pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Storage is left as-is so the head outputs simply hold while empty.
            pc     <= bus.redirect_pc & 32'hFFFF_FFFC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]    <= pc;
                mem_instr[wr_ptr] <= bus.rom_data;
                wr_ptr            <= wr_ptr + 1'b1;
                pc                <= pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign bus.rom_addr    = pc;
    assign bus.if_valid    = (count != '0);
    assign bus.if_instr    = mem_instr[rd_ptr];
    assign bus.if_pc       = mem_pc[rd_ptr];
    assign bus.if_pc_plus4 = mem_pc[rd_ptr] + 32'd4;
    assign bus.q_count     = count;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed-vector bench for if_fetch_ctrl
module tb_if_fetch_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   vec_count = 0;
    int   err_count = 0;

    if_fetch_ctrl_if #(.DEPTH(2)) bus ();

    if_fetch_ctrl #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = {16'hCAFE, bus.rom_addr[15:0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_count++;
        if (obs !== exp_v) begin
            err_count++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic v, input logic [31:0] pc_v);
        check({tag, ".valid"}, {31'd0, bus.if_valid}, {31'd0, v});
        if (v) begin
            check({tag, ".pc"},    bus.if_pc,    pc_v);
            check({tag, ".instr"}, bus.if_instr, {16'hCAFE, pc_v[15:0]});
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid"}, {31'd0, bus.if_valid}, 32'd0);
        check({tag, ".cnt"},   {30'd0, bus.q_count},  32'd0);
        check({tag, ".instr"}, bus.if_instr,          32'd0);
        check({tag, ".pc"},    bus.if_pc,             32'd0);
        check({tag, ".pc4"},   bus.if_pc_plus4,       32'd4);
        check({tag, ".addr"},  bus.rom_addr,          32'd0);
    endtask

    initial begin
        reset              = 1'b0;
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.id_ready       = 1'b1;
        tick();
        check_reset_state("rst");

        // release with id_ready=1: BOOT, push at 2nd edge, then one per cycle
        reset = 1'b1;
        tick();
        check_head("s1.c2", 1'b0, 32'd0);
        check("s1.c2.addr", bus.rom_addr, 32'd0);
        tick();
        check_head("s1.c3", 1'b1, 32'd0);
        check("s1.c3.cnt", {30'd0, bus.q_count}, 32'd1);
        check("s1.c3.addr", bus.rom_addr, 32'd4);
        tick();
        check_head("s1.c4", 1'b1, 32'd4);
        tick();
        check_head("s1.c5", 1'b1, 32'd8);
        tick();
        check_head("s1.c6", 1'b1, 32'd12);

        // back-pressure from reset: queue fills to 2, PC parks at 8
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.id_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("s2.cnt", {30'd0, bus.q_count}, 32'd2);
        check("s2.addr", bus.rom_addr, 32'd8);
        check_head("s2.hold", 1'b1, 32'd0);
        bus.id_ready = 1'b1;
        tick();
        check_head("s2.d1", 1'b1, 32'd4);
        check("s2.d1.cnt", {30'd0, bus.q_count}, 32'd2);
        tick();
        check_head("s2.d2", 1'b1, 32'd8);
        check("s2.d2.addr", bus.rom_addr, 32'd16);

        // redirect while full, low bits of target dropped
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0033;
        tick();
        bus.redirect_valid = 1'b0;
        check("s3.cnt", {30'd0, bus.q_count}, 32'd0);
        check("s3.valid", {31'd0, bus.if_valid}, 32'd0);
        check("s3.addr", bus.rom_addr, 32'h30);
        tick();
        check_head("s3.tgt", 1'b1, 32'h30);

        // freeze: queue drains, PC stays, resumes at the frozen PC
        bus.fetch_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("s4.cnt", {30'd0, bus.q_count}, 32'd0);
        check("s4.valid", {31'd0, bus.if_valid}, 32'd0);
        check("s4.addr", bus.rom_addr, 32'h34);
        bus.fetch_en = 1'b1;
        tick();
        check("s4.wake.valid", {31'd0, bus.if_valid}, 32'd0);
        check("s4.wake.addr", bus.rom_addr, 32'h34);
        tick();
        check_head("s4.r1", 1'b1, 32'h34);
        tick();
        check_head("s4.r2", 1'b1, 32'h38);

        // PC wrap at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        check("s5.addr", bus.rom_addr, 32'hFFFF_FFFC);
        tick();
        check_head("s5.top", 1'b1, 32'hFFFF_FFFC);
        check("s5.pc4", bus.if_pc_plus4, 32'd0);
        tick();
        check_head("s5.wrap", 1'b1, 32'd0);
        check("s5.wrap.addr", bus.rom_addr, 32'd4);

        // mid-stream reset with a full queue
        bus.id_ready = 1'b0;
        tick();
        tick();
        check("s6.full", {30'd0, bus.q_count}, 32'd2);
        reset = 1'b0;
        bus.id_ready = 1'b1;
        tick();
        check_reset_state("s6.rst");
        reset = 1'b1;
        tick();
        check_head("s6.c2", 1'b0, 32'd0);
        tick();
        check_head("s6.c3", 1'b1, 32'd0);
        tick();
        check_head("s6.c4", 1'b1, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule
